// File: rtl/quiz_round_ctrl_pkg.sv
// Shared types and constants for the quiz round controller: FSM state codes,
// the generator's operator codes and the score ceiling.
package quiz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REWARD = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] SCORE_MAX = 4'd9;

    // Score increment that sticks at SCORE_MAX.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
    endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Bundle of the quiz controller's game-side signals. The master side is the
// controller itself; the slave side is the surrounding board/generator.
interface quiz_round_ctrl_if;

    logic       start;
    logic       prob_req;
    logic       prob_ack;
    logic [1:0] prob_op;
    logic [3:0] answer;
    logic       show;
    logic [3:0] score;
    logic [3:0] round;
    logic       celebrate;
    logic       timeout;
    logic       game_over;
    logic [2:0] state;

    modport master (
        input  start, prob_ack, prob_op, answer,
        output prob_req, show, score, round, celebrate, timeout, game_over, state
    );

    modport slave (
        output start, prob_ack, prob_op, answer,
        input  prob_req, show, score, round, celebrate, timeout, game_over, state
    );

endinterface

// File: rtl/quiz_round_ctrl_press.sv
// Switch edge detector: registers the operator switches and reports which
// switches went from off to on this cycle, whether exactly one did, and
// whether every switch is currently off.
module quiz_press_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] answer_i,
    output logic [3:0] press_o,
    output logic       onehot_o,
    output logic       released_o
);

    logic [3:0] answer_q;

    // Previous switch sample, used to find new presses.
    always_ff @(posedge clk) begin
        if (reset) answer_q <= 4'd0;
        else       answer_q <= answer_i;
    end

    assign press_o    = answer_i & ~answer_q;
    assign onehot_o   = $onehot(press_o);
    assign released_o = (answer_i == 4'd0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the operator quiz: requests problems, gates the
// displays, judges switch presses and keeps score/round counts.
// Optional feature: define QUIZ_TIMEOUT_EN to add an answer-window timer
// that ends a round as wrong after TIMEOUT_CYCLES cycles in WAIT.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int ROUNDS           = 9,
    parameter int TIMEOUT_CYCLES   = 50_000_000,
    parameter int CELEBRATE_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    quiz_round_ctrl_if.master bus
);

    if (ROUNDS < 1 || ROUNDS > 15 || TIMEOUT_CYCLES < 2 || CELEBRATE_CYCLES < 1) begin : g_param_check
        $error("quiz_round_ctrl: parameter out of range");
    end

    localparam int               CEL_W    = $clog2(CELEBRATE_CYCLES + 1);
    localparam logic [CEL_W-1:0] CEL_LAST = CEL_W'(CELEBRATE_CYCLES - 1);
    localparam logic [3:0]       ROUNDS_4 = 4'(ROUNDS);

    state_t           state_q, state_d;
    logic [3:0]       score_q, score_d;
    logic [3:0]       round_q, round_d;
    logic [1:0]       op_q, op_d;
    logic [CEL_W-1:0] cel_q, cel_d;
    logic             start_q;
    logic             start_edge;
    logic             timeout_d;

    logic             prob_req_q, show_q, celebrate_q, timeout_q, game_over_q;

    logic [3:0]       press;
    logic             press_one;
    logic             released;
    logic [3:0]       round_inc;
    state_t           after_judge;

`ifdef QUIZ_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    quiz_press_detect u_press (
        .clk        (clk),
        .reset      (reset),
        .answer_i   (bus.answer),
        .press_o    (press),
        .onehot_o   (press_one),
        .released_o (released)
    );

    // Previous start level, for rising-edge detection of the button.
    always_ff @(posedge clk) begin
        if (reset) start_q <= 1'b0;
        else       start_q <= bus.start;
    end

    assign start_edge  = bus.start & ~start_q;
    // Round count after the round being judged now, and where that leads.
    assign round_inc   = round_q + 4'd1;
    assign after_judge = (round_inc == ROUNDS_4) ? ST_DONE : ST_REQ;

    // Next-state, counter and judging logic.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        round_d   = round_q;
        op_d      = op_q;
        cel_d     = cel_q;
        timeout_d = 1'b0;
`ifdef QUIZ_TIMEOUT_EN
        tmr_d     = tmr_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    score_d = 4'd0;
                    round_d = 4'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.prob_ack) begin
                    op_d    = bus.prob_op;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // A switch still up from the previous round must come down first.
                if (released) begin
                    state_d = ST_WAIT;
`ifdef QUIZ_TIMEOUT_EN
                    tmr_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
`ifdef QUIZ_TIMEOUT_EN
                tmr_d = tmr_q + TMR_W'(1);
`endif
                if (press != 4'd0) begin
                    round_d = round_inc;
                    if (press_one && press[op_q]) begin
                        score_d = score_inc(score_q);
                        cel_d   = '0;
                        state_d = ST_REWARD;
                    end else begin
                        state_d = after_judge;
                    end
                end
`ifdef QUIZ_TIMEOUT_EN
                else if (tmr_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    round_d   = round_inc;
                    state_d   = after_judge;
                end
`endif
            end
            ST_REWARD: begin
                cel_d = cel_q + CEL_W'(1);
                if (cel_q == CEL_LAST) begin
                    state_d = (round_q == ROUNDS_4) ? ST_DONE : ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            score_q     <= 4'd0;
            round_q     <= 4'd0;
            op_q        <= 2'd0;
            cel_q       <= '0;
            prob_req_q  <= 1'b0;
            show_q      <= 1'b0;
            celebrate_q <= 1'b0;
            timeout_q   <= 1'b0;
            game_over_q <= 1'b0;
`ifdef QUIZ_TIMEOUT_EN
            tmr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            round_q     <= round_d;
            op_q        <= op_d;
            cel_q       <= cel_d;
            prob_req_q  <= (state_d == ST_REQ);
            show_q      <= (state_d == ST_ARM) || (state_d == ST_WAIT);
            celebrate_q <= (state_d == ST_REWARD);
            timeout_q   <= timeout_d;
            game_over_q <= (state_d == ST_DONE);
`ifdef QUIZ_TIMEOUT_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    assign bus.prob_req  = prob_req_q;
    assign bus.show      = show_q;
    assign bus.score     = score_q;
    assign bus.round     = round_q;
    assign bus.celebrate = celebrate_q;
    assign bus.timeout   = timeout_q;
    assign bus.game_over = game_over_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: a 3-round instance for most scenarios and a
// 12-round instance for score saturation, both fed the same stimulus.
module tb_quiz_round_ctrl;
    import quiz_pkg::*;

    typedef struct {
        logic [3:0] score;
        logic [3:0] round;
        logic       cel;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_r = 1'b0;
    logic       ack_r = 1'b0;
    logic [1:0] op_r = 2'd0;
    logic [3:0] answer_r = 4'd0;
    logic       sel12 = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    quiz_round_ctrl_if bus ();
    quiz_round_ctrl_if bus12 ();

    assign bus.start     = start_r;
    assign bus.prob_ack  = ack_r;
    assign bus.prob_op   = op_r;
    assign bus.answer    = answer_r;
    assign bus12.start    = start_r;
    assign bus12.prob_ack = ack_r;
    assign bus12.prob_op  = op_r;
    assign bus12.answer   = answer_r;

    quiz_round_ctrl #(.ROUNDS(3), .TIMEOUT_CYCLES(8), .CELEBRATE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    quiz_round_ctrl #(.ROUNDS(12), .TIMEOUT_CYCLES(8), .CELEBRATE_CYCLES(4)) dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12)
    );

    always #5 clk = ~clk;

    logic [2:0] o_st;
    logic [3:0] o_score, o_round;
    logic       o_req, o_show, o_cel, o_tmo, o_go;
    assign o_st    = sel12 ? bus12.state     : bus.state;
    assign o_score = sel12 ? bus12.score     : bus.score;
    assign o_round = sel12 ? bus12.round     : bus.round;
    assign o_req   = sel12 ? bus12.prob_req  : bus.prob_req;
    assign o_show  = sel12 ? bus12.show      : bus.show;
    assign o_cel   = sel12 ? bus12.celebrate : bus.celebrate;
    assign o_tmo   = sel12 ? bus12.timeout   : bus.timeout;
    assign o_go    = sel12 ? bus12.game_over : bus.game_over;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset, then a start edge; returns sampled in REQ.
    task automatic new_game();
        reset = 1'b1; ack_r = 1'b0; answer_r = 4'd0; start_r = 1'b0;
        ticks(2);
        reset = 1'b0;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
    endtask

    // One ack cycle, then one ARM cycle; returns sampled in WAIT when switches are down.
    task automatic ack_to_wait(input logic [1:0] op);
        op_r = op;
        ack_r = 1'b1;
        tick();
        ack_r = 1'b0;
        tick();
    endtask

    task automatic press_exp(input logic [3:0] ans, input exp_t e);
        answer_r = ans;
        sbq.push_back(e);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ticks(2);
        checks++;
        if ({o_req, o_show, o_cel, o_tmo, o_go} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {o_req, o_show, o_cel, o_tmo, o_go});
        end
        checks++;
        if (o_score !== 4'd0 || o_round !== 4'd0) begin
            errors++;
            $display("FAIL reset_counts got score=%0d round=%0d want 0 0", o_score, o_round);
        end
        checks++;
        if (o_st !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", o_st);
        end
    endtask

    task automatic test_correct();
        exp_t e;
        new_game();
        checks++;
        if (o_req !== 1'b1 || o_st !== 3'd1) begin
            errors++;
            $display("FAIL start_req got req=%b st=%0d want 1 1", o_req, o_st);
        end
        ack_to_wait(OP_MUL);
        checks++;
        if (o_st !== 3'd3 || o_show !== 1'b1 || o_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_to_wait got st=%0d show=%b req=%b want 3 1 0", o_st, o_show, o_req);
        end
        press_exp(4'b0100, '{score: 4'd1, round: 4'd1, cel: 1'b1});
        e = sbq.pop_front();
        checks++;
        if (o_score !== e.score || o_round !== e.round || o_cel !== e.cel) begin
            errors++;
            $display("FAIL correct_judge got score=%0d round=%0d cel=%b want %0d %0d %b",
                     o_score, o_round, o_cel, e.score, e.round, e.cel);
        end
        answer_r = 4'd0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++;
            if (o_cel !== 1'b1) begin
                errors++;
                $display("FAIL celebrate_len cycle %0d got %b want 1", i, o_cel);
            end
        end
        tick();
        checks++;
        if (o_cel !== 1'b0 || o_req !== 1'b1) begin
            errors++;
            $display("FAIL celebrate_end got cel=%b req=%b want 0 1", o_cel, o_req);
        end
    endtask

    task automatic test_wrong();
        exp_t e;
        new_game();
        ack_to_wait(OP_ADD);
        press_exp(4'b0010, '{score: 4'd0, round: 4'd1, cel: 1'b0});
        e = sbq.pop_front();
        checks++;
        if (o_score !== e.score || o_round !== e.round || o_cel !== e.cel || o_req !== 1'b1) begin
            errors++;
            $display("FAIL wrong_judge got score=%0d round=%0d cel=%b req=%b want %0d %0d %b 1",
                     o_score, o_round, o_cel, o_req, e.score, e.round, e.cel);
        end
        answer_r = 4'd0;
        ack_to_wait(OP_ADD);
        press_exp(4'b0011, '{score: 4'd0, round: 4'd2, cel: 1'b0});
        e = sbq.pop_front();
        checks++;
        if (o_score !== e.score || o_round !== e.round || o_cel !== e.cel) begin
            errors++;
            $display("FAIL multi_press got score=%0d round=%0d cel=%b want %0d %0d %b",
                     o_score, o_round, o_cel, e.score, e.round, e.cel);
        end
        answer_r = 4'd0;
    endtask

    task automatic test_held();
        exp_t e;
        new_game();
        ack_to_wait(OP_ADD);
        press_exp(4'b0001, '{score: 4'd1, round: 4'd1, cel: 1'b1});
        e = sbq.pop_front();
        checks++;
        if (o_score !== e.score || o_round !== e.round) begin
            errors++;
            $display("FAIL held_first got score=%0d round=%0d want %0d %0d", o_score, o_round, e.score, e.round);
        end
        ticks(4);
        ack_to_wait(OP_ADD);
        ticks(3);
        checks++;
        if (o_st !== 3'd2 || o_score !== 4'd1) begin
            errors++;
            $display("FAIL held_arm got st=%0d score=%0d want 2 1", o_st, o_score);
        end
        answer_r = 4'd0;
        tick();
        checks++;
        if (o_st !== 3'd3) begin
            errors++;
            $display("FAIL held_release got st=%0d want 3", o_st);
        end
        press_exp(4'b0001, '{score: 4'd2, round: 4'd2, cel: 1'b1});
        e = sbq.pop_front();
        checks++;
        if (o_score !== e.score || o_round !== e.round || o_cel !== e.cel) begin
            errors++;
            $display("FAIL held_repress got score=%0d round=%0d cel=%b want %0d %0d %b",
                     o_score, o_round, o_cel, e.score, e.round, e.cel);
        end
        answer_r = 4'd0;
    endtask

    task automatic test_timeout();
        new_game();
        ack_to_wait(OP_SUB);
        checks++;
        if (o_st !== 3'd3) begin
            errors++;
            $display("FAIL timeout_enter got st=%0d want 3", o_st);
        end
`ifdef QUIZ_TIMEOUT_EN
        begin
            exp_t e;
            int   early = 0;
            for (int i = 0; i < 7; i++) begin
                tick();
                if (o_tmo !== 1'b0 || o_st !== 3'd3) early++;
            end
            checks++;
            if (early != 0) begin
                errors++;
                $display("FAIL timeout_early got %0d bad cycles want 0", early);
            end
            sbq.push_back('{score: 4'd0, round: 4'd1, cel: 1'b0});
            tick();
            e = sbq.pop_front();
            checks++;
            if (o_tmo !== 1'b1 || o_round !== e.round || o_score !== e.score) begin
                errors++;
                $display("FAIL timeout_pulse got tmo=%b round=%0d score=%0d want 1 %0d %0d",
                         o_tmo, o_round, o_score, e.round, e.score);
            end
            tick();
            checks++;
            if (o_tmo !== 1'b0) begin
                errors++;
                $display("FAIL timeout_oneshot got %b want 0", o_tmo);
            end
        end
`else
        ticks(100);
        checks++;
        if (o_st !== 3'd3 || o_tmo !== 1'b0 || o_round !== 4'd0) begin
            errors++;
            $display("FAIL no_timeout got st=%0d tmo=%b round=%0d want 3 0 0", o_st, o_tmo, o_round);
        end
`endif
    endtask

    // Plays n all-correct rounds on the selected instance, checking each judgement.
    task automatic play_correct(input int n, input string tag);
        exp_t e;
        for (int r = 1; r <= n; r++) begin
            logic [1:0] op;
            op = 2'(r % 4);
            ack_to_wait(op);
            press_exp(4'b0001 << op, '{score: (r > 9) ? 4'd9 : 4'(r), round: 4'(r), cel: 1'b1});
            e = sbq.pop_front();
            checks++;
            if (o_score !== e.score || o_round !== e.round || o_cel !== e.cel) begin
                errors++;
                $display("FAIL %s round %0d got score=%0d round=%0d cel=%b want %0d %0d %b",
                         tag, r, o_score, o_round, o_cel, e.score, e.round, e.cel);
            end
            answer_r = 4'd0;
            ticks(4);
        end
    endtask

    task automatic test_game_end();
        new_game();
        play_correct(3, "game3");
        checks++;
        if (o_go !== 1'b1 || o_score !== 4'd3 || o_st !== 3'd5 || o_show !== 1'b0) begin
            errors++;
            $display("FAIL game_over got go=%b score=%0d st=%0d show=%b want 1 3 5 0", o_go, o_score, o_st, o_show);
        end
        ticks(3);
        checks++;
        if (o_score !== 4'd3 || o_go !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got score=%0d go=%b want 3 1", o_score, o_go);
        end
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        checks++;
        if (o_score !== 4'd0 || o_round !== 4'd0 || o_req !== 1'b1 || o_go !== 1'b0) begin
            errors++;
            $display("FAIL restart got score=%0d round=%0d req=%b go=%b want 0 0 1 0", o_score, o_round, o_req, o_go);
        end
    endtask

    task automatic test_saturation();
        sel12 = 1'b1;
        new_game();
        play_correct(12, "sat12");
        checks++;
        if (o_score !== 4'd9 || o_round !== 4'd12 || o_go !== 1'b1) begin
            errors++;
            $display("FAIL saturation_end got score=%0d round=%0d go=%b want 9 12 1", o_score, o_round, o_go);
        end
        sel12 = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        exp_t e;
        new_game();
        ack_to_wait(OP_DIV);
        press_exp(4'b1000, '{score: 4'd1, round: 4'd1, cel: 1'b1});
        e = sbq.pop_front();
        answer_r = 4'd0;
        ticks(4);
        checks++;
        if (o_req !== 1'b1 || o_score !== e.score) begin
            errors++;
            $display("FAIL pre_reset got req=%b score=%0d want 1 %0d", o_req, o_score, e.score);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (o_st !== 3'd0 || o_req !== 1'b0 || o_score !== 4'd0 || o_round !== 4'd0) begin
            errors++;
            $display("FAIL mid_req_reset got st=%0d req=%b score=%0d round=%0d want 0 0 0 0",
                     o_st, o_req, o_score, o_round);
        end
        reset = 1'b0;
        op_r = OP_MUL;
        ack_r = 1'b1;
        tick();
        ack_r = 1'b0;
        tick();
        checks++;
        if (o_st !== 3'd0 || o_req !== 1'b0 || o_show !== 1'b0) begin
            errors++;
            $display("FAIL late_ack got st=%0d req=%b show=%b want 0 0 0", o_st, o_req, o_show);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_wrong();
        test_held();
        test_timeout();
        test_game_end();
        test_saturation();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
